// File: rtl/ifu_pc_gen_if.sv
// Fetch-side bus bundle for ifu_pc_gen.
// master: the PC generator (drives the fetch request and the held instruction).
// slave : the environment (instruction memory plus IDU).
//   imem_req_valid_o/imem_req_ready_i/imem_addr_o : fetch request handshake
//   imem_rsp_valid_i/imem_rsp_data_i              : one-cycle fetch response
//   inst_valid_o/inst_ready_i/inst_o/pc_o         : instruction held for the IDU
interface ifu_pc_gen_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              imem_req_valid_o;
    logic              imem_req_ready_i;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_rsp_valid_i;
    logic [INST_W-1:0] imem_rsp_data_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] pc_o;

    modport master (
        output imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, inst_ready_i
    );
endinterface

// File: rtl/ifu_pc_gen.sv
// Fetch PC generator / instruction sequencer. Issues one outstanding fetch at
// a time, holds the returned instruction for the IDU, and follows decode-stage
// redirects, discarding any fetch that a redirect has made stale.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   branch_en_i  redirect strobe from the decode branch unit
//   dnpc_i       redirect target (low two bits ignored)
//   bus          ifu_pc_gen_if.master: imem request/response and IDU handshake
module ifu_pc_gen #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_en_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    ifu_pc_gen_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              req_valid_q;
    logic              inst_valid_q;
    logic [ADDR_W-1:0] pc_new;
    logic              req_hs;

    // Redirect targets are word aligned.
    assign pc_new = dnpc_i & ~ADDR_W'(3);
    assign req_hs = req_valid_q & bus.imem_req_ready_i;

    // Next-state, next-PC and instruction capture.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (branch_en_i) pc_d = pc_new;
            end
            S_REQ: begin
                if (branch_en_i) begin
                    pc_d = pc_new;
                    // An accepted old-PC fetch must still be drained.
                    if (req_hs) state_d = S_DROP;
                end else if (req_hs) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_en_i) begin
                    pc_d    = pc_new;
                    state_d = bus.imem_rsp_valid_i ? S_REQ : S_DROP;
                end else if (bus.imem_rsp_valid_i) begin
                    inst_d  = bus.imem_rsp_data_i;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_en_i) begin
                    pc_d    = pc_new;
                    state_d = S_REQ;
                end else if (bus.inst_ready_i) begin
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (branch_en_i) pc_d = pc_new;
                if (bus.imem_rsp_valid_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, instruction and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            req_valid_q  <= (state_d == S_REQ);
            inst_valid_q <= (state_d == S_HOLD);
        end
    end

    assign bus.imem_req_valid_o = req_valid_q;
    assign bus.imem_addr_o      = pc_q;
    assign bus.inst_valid_o     = inst_valid_q;
    assign bus.inst_o           = inst_q;
    assign bus.pc_o             = pc_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Bench for ifu_pc_gen: directed scenarios plus randomized traffic, checked
// against a transaction-level model (expected fetch PC, outstanding fetch,
// staleness and held instruction) and a latency-programmable memory model.
module tb_ifu_pc_gen;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] dnpc = '0;

    int total = 0;
    int bad   = 0;

    // Model state
    bit          m_idle, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_inst;
    // Memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          lat_cfg;
    logic [31:0] seen_q[$];

    ifu_pc_gen_if #(.ADDR_W(32), .INST_W(32)) bus ();

    ifu_pc_gen #(.ADDR_W(32), .INST_W(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_en_i (branch_en),
        .dnpc_i      (dnpc),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit ereq;
        ereq = !m_idle && !m_out && !m_hold;
        chk("req_valid", 32'(bus.imem_req_valid_o), 32'(ereq));
        if (ereq) chk("req_addr", bus.imem_addr_o, m_pc);
        chk("inst_valid", 32'(bus.inst_valid_o), 32'(m_hold));
        if (m_hold) begin
            chk("inst", bus.inst_o, m_inst);
            chk("pc", bus.pc_o, m_pc);
        end
    endtask

    task automatic chk_seen(input string tag, input int idx, input logic [31:0] exp);
        if (idx < seen_q.size()) chk(tag, seen_q[idx], exp);
        else chk({tag, "_cnt"}, 32'(seen_q.size()), 32'(idx + 1));
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check
    // the outputs at the next falling edge.
    task automatic step(input bit br, input logic [31:0] dn, input bit rr,
                        input bit ir, input bit spur);
        bit          rsp_now, rsp, ereq, hs, cons;
        logic [31:0] rdata, pc_new;
        rsp_now = mem_busy && (mem_cnt == 1);
        rsp     = rsp_now || (spur && !m_out);
        rdata   = rsp_now ? mem_word(mem_addr) : 32'($urandom);

        branch_en            = br;
        dnpc                 = dn;
        bus.imem_req_ready_i = rr;
        bus.inst_ready_i     = ir;
        bus.imem_rsp_valid_i = rsp;
        bus.imem_rsp_data_i  = rdata;
        if (bus.imem_req_valid_o && rr) seen_q.push_back(bus.imem_addr_o);

        ereq   = !m_idle && !m_out && !m_hold;
        hs     = ereq && rr;
        cons   = m_hold && ir;
        pc_new = dn & ~32'd3;

        if (mem_busy) begin
            if (rsp_now) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (m_out && rsp) begin
            m_out = 1'b0;
            if (!m_stale && !br) begin
                m_hold = 1'b1;
                m_inst = rdata;
            end
        end else if (m_hold && (cons || br)) begin
            m_hold = 1'b0;
        end
        if (m_out && br) m_stale = 1'b1;
        if (hs) begin
            m_out    = 1'b1;
            m_stale  = br;
            mem_busy = 1'b1;
            mem_addr = m_pc;
            mem_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        end
        if (br) m_pc = pc_new;
        else if (cons) m_pc = m_pc + 32'd4;
        m_idle = 1'b0;

        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n, input bit rr, input bit ir);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, ir, 1'b0);
    endtask

    // Reset asserted mid-cycle; outputs must drop immediately.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'h0);
        chk("rst_pc", bus.pc_o, RST_PC);
        chk("rst_addr", bus.imem_addr_o, RST_PC);
        branch_en            = 1'b0;
        dnpc                 = '0;
        bus.imem_req_ready_i = 1'b0;
        bus.inst_ready_i     = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        m_idle   = 1'b1;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_hold   = 1'b0;
        m_pc     = RST_PC;
        m_inst   = '0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        seen_q.delete();
        @(negedge clk);
        rst = 1'b1;
        check_outputs();
    endtask

    initial begin
        bus.imem_req_ready_i = 1'b0;
        bus.inst_ready_i     = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = '0;
        lat_cfg = 1;

        // Streaming fetch, everything ready, 1-cycle memory.
        do_reset();
        run(12, 1'b1, 1'b1);
        chk_seen("seq0", 0, 32'h8000_0000);
        chk_seen("seq1", 1, 32'h8000_0004);
        chk_seen("seq2", 2, 32'h8000_0008);

        // IDU stall in HOLD for 5 cycles.
        do_reset();
        run(3, 1'b1, 1'b0);
        run(5, 1'b1, 1'b0);
        chk("stall_one_req", 32'(seen_q.size()), 32'd1);
        run(4, 1'b1, 1'b1);
        chk_seen("stall_next", 1, 32'h8000_0004);

        // Redirect in WAIT, response 3 cycles after acceptance.
        do_reset();
        lat_cfg = 3;
        run(2, 1'b1, 1'b1);
        step(1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1);
        chk_seen("wait_rd0", 0, 32'h8000_0000);
        chk_seen("wait_rd1", 1, 32'h8000_0100);

        // Redirect together with the instruction handshake.
        do_reset();
        lat_cfg = 1;
        step(1'b1, 32'h8000_0010, 1'b1, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0);
        step(1'b1, 32'h8000_0041, 1'b1, 1'b1, 1'b0);
        run(4, 1'b1, 1'b1);
        chk_seen("hold_rd0", 0, 32'h8000_0010);
        chk_seen("hold_rd1", 1, 32'h8000_0040);

        // Redirect in REQ with the request accepted the same cycle.
        do_reset();
        lat_cfg = 2;
        run(1, 1'b1, 1'b1);
        step(1'b1, 32'h8000_0200, 1'b1, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1);
        chk_seen("req_rd0", 0, 32'h8000_0000);
        chk_seen("req_rd1", 1, 32'h8000_0200);

        // PC wrap at the top of the address space.
        do_reset();
        lat_cfg = 1;
        step(1'b1, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b0);
        run(8, 1'b1, 1'b1);
        chk_seen("wrap0", 0, 32'hFFFF_FFFC);
        chk_seen("wrap1", 1, 32'h0000_0000);

        // Reset while in WAIT, then a stray response in IDLE.
        do_reset();
        lat_cfg = 4;
        run(3, 1'b1, 1'b1);
        do_reset();
        lat_cfg = 1;
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        run(6, 1'b1, 1'b1);
        chk_seen("rst_restart", 0, 32'h8000_0000);

        // Randomized traffic.
        do_reset();
        lat_cfg = 0;
        for (int i = 0; i < 3000; i++) begin
            bit          br, rr, ir, sp;
            logic [31:0] dn;
            br = ($urandom_range(0, 7) == 0);
            dn = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
            rr = ($urandom_range(0, 9) < 7);
            ir = ($urandom_range(0, 9) < 6);
            sp = ($urandom_range(0, 19) == 0);
            step(br, dn, rr, ir, sp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
